// File: rtl/ucsbece154_mem_arbiter.sv
// Block-read arbiter: shares one SDRAM controller burst port between the I-cache and the
// D-side refill requester, granting whole bursts round-robin and steering beats to the owner.
`timescale 1ns/1ps

module ucsbece154_mem_arbiter #(
    parameter int BLOCK_WORDS = 4,
    parameter int WORD_SIZE   = 32
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic                 IMemReadRequest,
    input  logic [31:0]          IMemReadAddress,
    output logic [WORD_SIZE-1:0] IMemDataIn,
    output logic                 IMemDataReady,
    input  logic                 DMemReadRequest,
    input  logic [31:0]          DMemReadAddress,
    output logic [WORD_SIZE-1:0] DMemDataIn,
    output logic                 DMemDataReady,
    output logic                 IGrant,
    output logic                 DGrant,
    output logic                 SdramReadRequest,
    output logic [31:0]          SdramReadAddress,
    input  logic [WORD_SIZE-1:0] SdramDataIn,
    input  logic                 SdramDataReady
);

    localparam int CNT_W = $clog2(BLOCK_WORDS);
    // Byte offset within a block: word index bits plus the two byte-in-word bits.
    localparam int OFF_W = CNT_W + 2;
    localparam logic [31:0]      ADDR_MASK = ~((32'd1 << OFF_W) - 32'd1);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BLOCK_WORDS - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic             OWN_I     = 1'b0;
    localparam logic             OWN_D     = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_BURST   = 2'd1,
        ST_RELEASE = 2'd2
    } state_t;

    state_t           state_r;
    state_t           next_state_s;
    logic             owner_r;
    logic             last_owner_r;
    logic [CNT_W-1:0] beat_cnt_r;
    logic             sdram_req_r;
    logic [31:0]      sdram_addr_r;

    logic             winner_s;
    logic [31:0]      winner_addr_s;
    logic             any_req_s;
    logic             start_s;
    logic             in_burst_s;
    logic             beat_s;
    logic             last_beat_s;

    assign any_req_s   = IMemReadRequest | DMemReadRequest;
    assign in_burst_s  = (state_r == ST_BURST);
    assign start_s     = (state_r == ST_IDLE) & any_req_s;
    assign beat_s      = in_burst_s & SdramDataReady;
    assign last_beat_s = beat_s & (beat_cnt_r == LAST_BEAT);

    // Winner selection: a lone requester wins, a tie goes to the side that did not own last.
    always_comb begin
        winner_s = OWN_I;
        if (IMemReadRequest && DMemReadRequest) begin
            winner_s = ~last_owner_r;
        end else if (DMemReadRequest) begin
            winner_s = OWN_D;
        end else begin
            winner_s = OWN_I;
        end
    end

    // Address of the winning side, used only at the grant edge.
    always_comb begin
        winner_addr_s = IMemReadAddress;
        if (winner_s == OWN_D) begin
            winner_addr_s = DMemReadAddress;
        end else begin
            winner_addr_s = IMemReadAddress;
        end
    end

    // Next-state logic for the IDLE -> BURST -> RELEASE cycle.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (any_req_s) begin
                    next_state_s = ST_BURST;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_BURST: begin
                if (last_beat_s) begin
                    next_state_s = ST_RELEASE;
                end else begin
                    next_state_s = ST_BURST;
                end
            end
            ST_RELEASE: begin
                next_state_s = ST_IDLE;
            end
            default: begin
                next_state_s = ST_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Ownership; last_owner resets to D so the first tie after reset goes to I.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            owner_r      <= OWN_I;
            last_owner_r <= OWN_D;
        end else if (start_s) begin
            owner_r      <= winner_s;
            last_owner_r <= winner_s;
        end else begin
            owner_r      <= owner_r;
            last_owner_r <= last_owner_r;
        end
    end

    // Beat counter: advances only on strobes inside a burst, wraps on the last beat.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            beat_cnt_r <= '0;
        end else if (start_s) begin
            beat_cnt_r <= '0;
        end else if (beat_s) begin
            beat_cnt_r <= beat_cnt_r + CNT_ONE;
        end else begin
            beat_cnt_r <= beat_cnt_r;
        end
    end

    // SDRAM request and block-aligned address; the address is left in place after a burst.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            sdram_req_r  <= 1'b0;
            sdram_addr_r <= 32'd0;
        end else if (start_s) begin
            sdram_req_r  <= 1'b1;
            sdram_addr_r <= winner_addr_s & ADDR_MASK;
        end else if (last_beat_s) begin
            sdram_req_r  <= 1'b0;
            sdram_addr_r <= sdram_addr_r;
        end else begin
            sdram_req_r  <= sdram_req_r;
            sdram_addr_r <= sdram_addr_r;
        end
    end

    assign SdramReadRequest = sdram_req_r;
    assign SdramReadAddress = sdram_addr_r;

    // Grant decode and zero-latency beat steering to the owner only.
    always_comb begin
        IGrant        = 1'b0;
        DGrant        = 1'b0;
        IMemDataReady = 1'b0;
        DMemDataReady = 1'b0;
        IMemDataIn    = '0;
        DMemDataIn    = '0;
        if (in_burst_s) begin
            if (owner_r == OWN_I) begin
                IGrant        = 1'b1;
                IMemDataReady = SdramDataReady;
                IMemDataIn    = SdramDataIn;
            end else begin
                DGrant        = 1'b1;
                DMemDataReady = SdramDataReady;
                DMemDataIn    = SdramDataIn;
            end
        end else begin
            IGrant        = 1'b0;
            DGrant        = 1'b0;
        end
    end

endmodule

// File: tb/tb_ucsbece154_mem_arbiter.sv
// Self-checking bench for ucsbece154_mem_arbiter: a scoreboard of expected beats (side, data)
// is filled as SDRAM beats are driven and drained by a monitor watching the cache-side strobes.
`timescale 1ns/1ps

module tb_ucsbece154_mem_arbiter;

    localparam logic SIDE_I = 1'b0;
    localparam logic SIDE_D = 1'b1;

    logic        Clk;
    logic        Reset;
    logic        IMemReadRequest;
    logic [31:0] IMemReadAddress;
    logic [31:0] IMemDataIn;
    logic        IMemDataReady;
    logic        DMemReadRequest;
    logic [31:0] DMemReadAddress;
    logic [31:0] DMemDataIn;
    logic        DMemDataReady;
    logic        IGrant;
    logic        DGrant;
    logic        SdramReadRequest;
    logic [31:0] SdramReadAddress;
    logic [31:0] SdramDataIn;
    logic        SdramDataReady;

    int n_checks = 0;
    int n_errors = 0;
    logic [32:0] sb_q[$];

    ucsbece154_mem_arbiter #(.BLOCK_WORDS(4), .WORD_SIZE(32)) dut (
        .Clk              (Clk),
        .Reset            (Reset),
        .IMemReadRequest  (IMemReadRequest),
        .IMemReadAddress  (IMemReadAddress),
        .IMemDataIn       (IMemDataIn),
        .IMemDataReady    (IMemDataReady),
        .DMemReadRequest  (DMemReadRequest),
        .DMemReadAddress  (DMemReadAddress),
        .DMemDataIn       (DMemDataIn),
        .DMemDataReady    (DMemDataReady),
        .IGrant           (IGrant),
        .DGrant           (DGrant),
        .SdramReadRequest (SdramReadRequest),
        .SdramReadAddress (SdramReadAddress),
        .SdramDataIn      (SdramDataIn),
        .SdramDataReady   (SdramDataReady)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Monitor: every cache-side strobe must match the oldest expected beat.
    always begin
        @(negedge Clk);
        #2;
        if (IMemDataReady || DMemDataReady) begin
            if (sb_q.size() == 0) begin
                check_val("unexpected_strobe", {30'd0, IMemDataReady, DMemDataReady}, 32'd0);
            end else begin
                logic [32:0] e;
                e = sb_q.pop_front();
                check_val("beat_side", {30'd0, IMemDataReady, DMemDataReady},
                          e[32] ? 32'd1 : 32'd2);
                check_val("beat_data", e[32] ? DMemDataIn : IMemDataIn, e[31:0]);
                check_val("nonowner_data", e[32] ? IMemDataIn : DMemDataIn, 32'd0);
            end
        end
    end

    task automatic check_reset_outputs();
        check_val("rst_grant", {30'd0, IGrant, DGrant}, 32'd0);
        check_val("rst_req", {31'd0, SdramReadRequest}, 32'd0);
        check_val("rst_addr", SdramReadAddress, 32'd0);
        check_val("rst_ready", {30'd0, IMemDataReady, DMemDataReady}, 32'd0);
        check_val("rst_idata", IMemDataIn, 32'd0);
        check_val("rst_ddata", DMemDataIn, 32'd0);
    endtask

    task automatic reset_dut();
        @(negedge Clk);
        Reset = 1'b0;
        IMemReadRequest = 1'b0;
        DMemReadRequest = 1'b0;
        SdramDataReady  = 1'b0;
        SdramDataIn     = 32'd0;
        #1;
        check_reset_outputs();
        @(negedge Clk);
        Reset = 1'b1;
    endtask

    task automatic check_idle(input bit pulse);
        @(negedge Clk);
        SdramDataReady = pulse;
        SdramDataIn    = pulse ? 32'h0000_DEAD : 32'd0;
        #1;
        check_val("idle_grant", {30'd0, IGrant, DGrant}, 32'd0);
        check_val("idle_req", {31'd0, SdramReadRequest}, 32'd0);
        check_val("idle_no_fwd", {30'd0, IMemDataReady, DMemDataReady}, 32'd0);
    endtask

    // One full burst, assuming the grant edge is the next rising edge.
    task automatic burst(input logic side, input logic [31:0] d0, input logic [31:0] addr,
                         input bit gaps, input int raise_d_at, input bit pulse_rel);
        logic [31:0] gexp;
        gexp = (side == SIDE_D) ? 32'd1 : 32'd2;
        @(negedge Clk);
        SdramDataIn    = d0;
        SdramDataReady = 1'b1;
        sb_q.push_back({side, d0});
        #1;
        check_val("grant", {30'd0, IGrant, DGrant}, gexp);
        check_val("sdram_req", {31'd0, SdramReadRequest}, 32'd1);
        check_val("sdram_addr", SdramReadAddress, addr);
        for (int i = 1; i < 4; i++) begin
            if (gaps) begin
                repeat (i) begin
                    @(negedge Clk);
                    SdramDataReady = 1'b0;
                    SdramDataIn    = 32'd0;
                    #1;
                    check_val("req_in_gap", {31'd0, SdramReadRequest}, 32'd1);
                end
            end
            @(negedge Clk);
            if (i == raise_d_at) DMemReadRequest = 1'b1;
            SdramDataIn    = d0 + i;
            SdramDataReady = 1'b1;
            sb_q.push_back({side, d0 + i});
            #1;
            check_val("grant_hold", {30'd0, IGrant, DGrant}, gexp);
            check_val("req_hold", {31'd0, SdramReadRequest}, 32'd1);
        end
        @(negedge Clk);
        SdramDataReady = pulse_rel;
        SdramDataIn    = pulse_rel ? 32'h0000_DEAD : 32'd0;
        #1;
        check_val("rel_grant", {30'd0, IGrant, DGrant}, 32'd0);
        check_val("rel_req", {31'd0, SdramReadRequest}, 32'd0);
        check_val("rel_addr_hold", SdramReadAddress, addr);
        check_val("rel_no_fwd", {30'd0, IMemDataReady, DMemDataReady}, 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        Reset = 1'b1;
        IMemReadRequest = 1'b0;
        IMemReadAddress = 32'd0;
        DMemReadRequest = 1'b0;
        DMemReadAddress = 32'd0;
        SdramDataIn     = 32'd0;
        SdramDataReady  = 1'b0;
        #1;
        Reset = 1'b0;
        #1;
        check_reset_outputs();

        // Single I burst.
        reset_dut();
        IMemReadRequest = 1'b1;
        IMemReadAddress = 32'h0000_1234;
        burst(SIDE_I, 32'h0000_00A0, 32'h0000_1230, 1'b0, -1, 1'b0);
        IMemReadRequest = 1'b0;
        check_idle(1'b0);
        check_idle(1'b0);

        // Both held from reset: I, D, I, D.
        @(negedge Clk);
        Reset = 1'b0;
        IMemReadRequest = 1'b1;
        DMemReadRequest = 1'b1;
        IMemReadAddress = 32'h0000_2008;
        DMemReadAddress = 32'h8000_0047;
        @(negedge Clk);
        Reset = 1'b1;
        burst(SIDE_I, 32'h0000_1000, 32'h0000_2000, 1'b0, -1, 1'b0);
        check_idle(1'b0);
        burst(SIDE_D, 32'h0000_2000, 32'h8000_0040, 1'b0, -1, 1'b0);
        check_idle(1'b0);
        burst(SIDE_I, 32'h0000_3000, 32'h0000_2000, 1'b0, -1, 1'b0);
        check_idle(1'b0);
        burst(SIDE_D, 32'h0000_4000, 32'h8000_0040, 1'b0, -1, 1'b0);
        IMemReadRequest = 1'b0;
        DMemReadRequest = 1'b0;
        check_idle(1'b0);

        // D request arrives mid I burst and waits for the turnaround.
        reset_dut();
        IMemReadRequest = 1'b1;
        IMemReadAddress = 32'h0000_0100;
        DMemReadAddress = 32'h0000_ABCD;
        burst(SIDE_I, 32'h0000_5000, 32'h0000_0100, 1'b0, 2, 1'b0);
        IMemReadRequest = 1'b0;
        check_idle(1'b0);
        burst(SIDE_D, 32'h0000_6000, 32'h0000_ABC0, 1'b0, -1, 1'b0);
        DMemReadRequest = 1'b0;
        check_idle(1'b0);

        // Idle cycles between beats.
        reset_dut();
        IMemReadRequest = 1'b1;
        IMemReadAddress = 32'h0000_0FFC;
        burst(SIDE_I, 32'h0000_7000, 32'h0000_0FF0, 1'b1, -1, 1'b0);
        IMemReadRequest = 1'b0;
        check_idle(1'b0);

        // Asynchronous reset after two beats, then a fresh burst from beat 0.
        reset_dut();
        IMemReadRequest = 1'b1;
        IMemReadAddress = 32'h0000_3004;
        @(negedge Clk);
        SdramDataIn = 32'h0000_00B0;
        SdramDataReady = 1'b1;
        sb_q.push_back({SIDE_I, 32'h0000_00B0});
        #1;
        check_val("mid_grant", {30'd0, IGrant, DGrant}, 32'd2);
        @(negedge Clk);
        SdramDataIn = 32'h0000_00B1;
        sb_q.push_back({SIDE_I, 32'h0000_00B1});
        @(negedge Clk);
        SdramDataReady = 1'b0;
        SdramDataIn = 32'd0;
        #3;
        Reset = 1'b0;
        SdramDataReady = 1'b1;
        SdramDataIn = 32'h0000_DEAD;
        #1;
        check_reset_outputs();
        @(negedge Clk);
        Reset = 1'b1;
        SdramDataReady = 1'b0;
        SdramDataIn = 32'd0;
        DMemReadRequest = 1'b1;
        DMemReadAddress = 32'h0000_4440;
        burst(SIDE_I, 32'h0000_00C0, 32'h0000_3000, 1'b0, -1, 1'b0);
        IMemReadRequest = 1'b0;
        DMemReadRequest = 1'b0;
        check_idle(1'b0);

        // Stray SDRAM strobes in IDLE and RELEASE are ignored.
        reset_dut();
        check_idle(1'b1);
        check_idle(1'b1);
        check_idle(1'b0);
        IMemReadRequest = 1'b1;
        IMemReadAddress = 32'h0000_5678;
        burst(SIDE_I, 32'h0000_00E0, 32'h0000_5670, 1'b0, -1, 1'b1);
        IMemReadRequest = 1'b0;
        check_idle(1'b1);
        check_idle(1'b0);
        DMemReadRequest = 1'b1;
        DMemReadAddress = 32'h0000_9999;
        burst(SIDE_D, 32'h0000_00F0, 32'h0000_9990, 1'b0, -1, 1'b0);
        DMemReadRequest = 1'b0;
        check_idle(1'b0);

        @(negedge Clk);
        #3;
        check_val("sb_leftover", sb_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
